// File: rtl/mem_streamer_pkg.sv
// Shared definitions for the memory streamer: state encoding, direction codes, default depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_streamer_pkg;

    localparam int DEFAULT_SIZE = 8192;
    localparam int ADDR_W       = 15;

    // Command direction as carried on cmd_write
    localparam logic DIR_LOAD = 1'b1;
    localparam logic DIR_DUMP = 1'b0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        LOAD_FLUSH = 3'd2,
        DUMP_FETCH = 3'd3,
        DUMP_SEND  = 3'd4,
        DONE       = 3'd5
    } state_t;

endpackage

// File: rtl/mem_streamer_addr_ctr.sv
// Transfer address register (wraps modulo SIZE) plus remaining-byte down-counter.
// Latency: addr/last update one cycle after load or step.
// Backpressure: none; the caller only steps on an accepted byte.
module mem_streamer_addr_ctr
    import mem_streamer_pkg::*;
#(
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    // SIZE is a power of two, so the wrap is a mask and upper address bits stay 0
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(SIZE - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(SIZE);

    logic [LEN_W-1:0] remaining;

    // Load start address and clamped length on command accept; advance per byte
    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= start_addr & ADDR_MASK;
            remaining <= (len > LEN_MAX) ? LEN_MAX : len;
        end else if (step) begin
            addr      <= (addr + 1'b1) & ADDR_MASK;
            remaining <= remaining - 1'b1;
        end
    end

    assign last = (remaining == LEN_W'(1));

endmodule

// File: rtl/mem_streamer.sv
// Memory bus initiator: streams bytes into memory (LOAD) or reads a region out (DUMP), holding the CPU meanwhile.
// Latency: LOAD writes one cycle after each accepted byte; DUMP presents a byte one cycle after its fetch.
// Backpressure: in_ready only in LOAD; DUMP holds out_data stable until out_ready; cmd_ready only in IDLE.
module mem_streamer
    import mem_streamer_pkg::*;
#(
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_wdata,
    output logic              mem_write_enable,
    output logic              mem_output_enable,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold
);

    state_t            state, state_n;
    logic              ctr_load, ctr_step;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic [ADDR_W-1:0] wr_addr;
    logic              load_accept;

    mem_streamer_addr_ctr #(
        .SIZE  (SIZE),
        .LEN_W (LEN_W)
    ) u_addr_ctr (
        .clk        (clk),
        .reset      (reset),
        .load       (ctr_load),
        .step       (ctr_step),
        .start_addr (cmd_addr),
        .len        (cmd_len),
        .addr       (addr),
        .last       (last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic and counter controls
    always_comb begin
        state_n  = state;
        ctr_load = 1'b0;
        ctr_step = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    ctr_load = 1'b1;
                    if (cmd_len == '0)            state_n = DONE;
                    else if (cmd_write == DIR_LOAD) state_n = LOAD;
                    else                          state_n = DUMP_FETCH;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    ctr_step = 1'b1;
                    if (last) state_n = LOAD_FLUSH;
                end
            end
            LOAD_FLUSH: state_n = DONE;
            DUMP_FETCH: state_n = DUMP_SEND;
            DUMP_SEND: begin
                if (out_ready) begin
                    ctr_step = 1'b1;
                    state_n  = last ? DONE : DUMP_FETCH;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign load_accept = (state == LOAD) && in_valid;

    // Write strobe is registered from the handshake so the memory samples it on the following negedge
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_write_enable <= 1'b0;
            wr_addr          <= '0;
            mem_wdata        <= '0;
        end else begin
            mem_write_enable <= load_accept;
            if (load_accept) begin
                wr_addr   <= addr;
                mem_wdata <= in_data;
            end
        end
    end

    // Capture the fetched byte and hold it until the consumer accepts it
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (state == DUMP_FETCH) begin
            out_data  <= mem_rdata;
            out_valid <= 1'b1;
        end else if (state == DUMP_SEND && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // During a fetch the live transfer address drives the bus; otherwise the last write address is held
    assign mem_address       = (state == DUMP_FETCH) ? addr : wr_addr;
    assign mem_output_enable = (state == DUMP_FETCH);
    assign cmd_ready         = (state == IDLE);
    assign in_ready          = (state == LOAD);
    assign busy              = (state != IDLE);
    assign done              = (state == DONE);
    assign cpu_hold          = busy;

endmodule

// File: tb/tb_mem_streamer.sv
// Bench for mem_streamer: directed LOAD/DUMP/wrap/zero-length/reset scenarios against a queue-based model.
// Latency: n/a.
// Backpressure: out_ready held high or randomly toggled per scenario.
module tb_mem_streamer;
    import mem_streamer_pkg::*;

    localparam int SIZE  = 8192;
    localparam int LEN_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [7:0]        out_data;
    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_wdata;
    logic              mem_write_enable;
    logic              mem_output_enable;
    logic [7:0]        mem_rdata;
    logic              busy;
    logic              done;
    logic              cpu_hold;

    always #5 clk = ~clk;

    mem_streamer #(.SIZE(SIZE), .LEN_W(LEN_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_len           (cmd_len),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .mem_address       (mem_address),
        .mem_wdata         (mem_wdata),
        .mem_write_enable  (mem_write_enable),
        .mem_output_enable (mem_output_enable),
        .mem_rdata         (mem_rdata),
        .busy              (busy),
        .done              (done),
        .cpu_hold          (cpu_hold)
    );

    // Shared byte memory: negedge write capture, combinational read
    logic [7:0] mem [SIZE];
    always @(negedge clk) begin
        if (mem_write_enable) mem[int'(mem_address) % SIZE] = mem_wdata;
    end
    assign mem_rdata = mem[int'(mem_address) % SIZE];

    // Reference model: expected memory image plus expected write and output streams
    logic [7:0] ref_mem [SIZE];
    int         exp_wa [$];
    logic [7:0] exp_wd [$];
    logic [7:0] exp_out [$];
    logic [7:0] sbuf [8];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_load(input int addr, input int n);
        for (int k = 0; k < n; k++) begin
            int a;
            a = (addr + k) % SIZE;
            ref_mem[a] = sbuf[k];
            exp_wa.push_back(a);
            exp_wd.push_back(sbuf[k]);
        end
    endtask

    task automatic model_dump(input int addr, input int len);
        int n;
        n = (len > SIZE) ? SIZE : len;
        for (int k = 0; k < n; k++) exp_out.push_back(ref_mem[(addr + k) % SIZE]);
    endtask

    // Per-cycle monitor state
    bit active = 0;
    bit prev_done = 0;
    bit prev_hs = 0;
    bit held_vld = 0;
    logic [7:0] held = '0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int we_run = 0;
    int we_max = 0;
    int busy_cycles = 0;
    bit rnd_ready = 0;

    // Compare process: checks every observable output each cycle against the model
    always @(negedge clk) begin
        if (active) begin
            chk("cpu_hold_eq_busy", int'(cpu_hold), int'(busy));
            chk("cmd_ready_eq_idle", int'(cmd_ready), int'(!busy));
            if (busy) busy_cycles++;
            if (mem_write_enable) begin
                we_run++;
                if (we_run > we_max) we_max = we_run;
                if (exp_wa.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    chk("write_addr", int'(mem_address), exp_wa.pop_front());
                    chk("write_data", int'(mem_wdata), int'(exp_wd.pop_front()));
                end
            end else begin
                we_run = 0;
            end
            if (out_valid) begin
                if (held_vld) chk("out_data_stable", int'(out_data), int'(held));
                if (prev_hs) chk("out_valid_gap", 1, 0);
                if (out_ready) begin
                    hs_cnt++;
                    if (exp_out.size() == 0) chk("unexpected_out", 1, 0);
                    else chk("out_data", int'(out_data), int'(exp_out.pop_front()));
                end
            end
            held_vld = out_valid && !out_ready;
            held     = out_data;
            prev_hs  = out_valid && out_ready;
            if (done) begin
                chk("done_single_pulse", int'(prev_done), 0);
                chk("done_while_busy", int'(busy), 1);
                chk("done_writes_drained", exp_wa.size(), 0);
                chk("done_out_drained", exp_out.size(), 0);
                done_cnt++;
            end
            prev_done = done;
        end
    end

    // out_ready driver: constant high or a coin flip every cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // All stimulus tasks start and end 1 time unit after a posedge
    task automatic issue(input logic wr, input int addr, input int len);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = ADDR_W'(addr);
        cmd_len   = LEN_W'(len);
        @(negedge clk);
        chk("cmd_ready_before_issue", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_bytes(input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            in_valid = 1'b1;
            in_data  = sbuf[k];
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!in_ready && t < 50);
            if (!in_ready) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int max);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < max) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int h0;
        logic [7:0] lit [4];

        for (int i = 0; i < SIZE; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cpu_hold", int'(cpu_hold), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_mem_address", int'(mem_address), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_mem_we", int'(mem_write_enable), 0);
        chk("rst_mem_oe", int'(mem_output_enable), 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        active = 1;

        // 1: LOAD 4 bytes back-to-back at 0x0100
        sbuf = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        model_load(32'h0100, 4);
        d0 = done_cnt; we_max = 0; busy_cycles = 0;
        issue(DIR_LOAD, 32'h0100, 4);
        send_bytes(4);
        in_valid = 1'b0;
        wait_idle(50);
        chk("t1_done_count", done_cnt - d0, 1);
        chk("t1_we_run", we_max, 4);
        chk("t1_busy_cycles", busy_cycles, 6);
        chk("t1_cpu_hold_after", int'(cpu_hold), 0);
        lit = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) chk("t1_mem", int'(mem[32'h0100 + i]), int'(lit[i]));

        // 2: DUMP the same region, consumer always ready
        model_dump(32'h0100, 4);
        d0 = done_cnt; h0 = hs_cnt; busy_cycles = 0;
        issue(DIR_DUMP, 32'h0100, 4);
        wait_idle(100);
        chk("t2_done_count", done_cnt - d0, 1);
        chk("t2_handshakes", hs_cnt - h0, 4);
        chk("t2_busy_cycles", busy_cycles, 9);

        // 4: LOAD across the top of memory
        sbuf = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00};
        model_load(32'h1FFE, 4);
        d0 = done_cnt;
        issue(DIR_LOAD, 32'h1FFE, 4);
        send_bytes(4);
        in_valid = 1'b0;
        wait_idle(50);
        chk("t4_done_count", done_cnt - d0, 1);
        chk("t4_mem_1ffe", int'(mem[32'h1FFE]), 32'hA0);
        chk("t4_mem_1fff", int'(mem[32'h1FFF]), 32'hA1);
        chk("t4_mem_0000", int'(mem[0]), 32'hA2);
        chk("t4_mem_0001", int'(mem[1]), 32'hA3);

        // 3: DUMP the wrapped region with a randomly stalling consumer
        model_dump(32'h1FFE, 4);
        d0 = done_cnt; h0 = hs_cnt;
        rnd_ready = 1;
        issue(DIR_DUMP, 32'h1FFE, 4);
        wait_idle(400);
        rnd_ready = 0;
        chk("t3_done_count", done_cnt - d0, 1);
        chk("t3_handshakes", hs_cnt - h0, 4);

        // 5: zero-length command is a no-op that still pulses done
        d0 = done_cnt; we_max = 0; busy_cycles = 0;
        issue(DIR_LOAD, 32'h0300, 0);
        wait_idle(20);
        chk("t5_done_count", done_cnt - d0, 1);
        chk("t5_busy_cycles", busy_cycles, 1);
        chk("t5_no_write", we_max, 0);

        // 6: reset after 2 of 6 LOAD bytes; byte 3 is offered during the reset edge
        sbuf = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h00, 8'h00};
        model_load(32'h0400, 2);
        d0 = done_cnt;
        issue(DIR_LOAD, 32'h0400, 6);
        send_bytes(2);
        in_data  = sbuf[2];
        in_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_busy", int'(busy), 0);
        chk("t6_cmd_ready", int'(cmd_ready), 1);
        chk("t6_we", int'(mem_write_enable), 0);
        repeat (3) @(negedge clk);
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_writes_drained", exp_wa.size(), 0);
        chk("t6_mem_0400", int'(mem[32'h0400]), 32'h61);
        chk("t6_mem_0401", int'(mem[32'h0401]), 32'h62);
        for (int i = 2; i < 6; i++) chk("t6_mem_untouched", int'(mem[32'h0400 + i]), 0);

        active = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
